// File: rtl/frame_mem_pkg.sv
// Shared types and default widths for the frame-memory arbiter, the HDMI
// transmitter fetch path and the image writer.
package frame_mem_pkg;

  localparam int FM_ADDR_W = 20;
  localparam int FM_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter timing one memory access; last_o flags the final
// cycle of the access (count at zero).
module arb_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port SRAM arbiter: read priority for the display fetch path, with an
// optional write-starvation guard enabled by FRAME_MEM_STARVE_GUARD_EN.
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int ADDR_W     = FM_ADDR_W,
  parameter int DATA_W     = FM_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int WR_CYC     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe,
  output logic              mem_we
);

  localparam int CNT_MAX = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;
  logic              cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              starve_full;
  logic              grant_rd, grant_wr;

  arb_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .last_o     (cnt_last)
  );

  assign grant_rd = (state_q == IDLE) && rd_req && !(wr_req && starve_full);
  assign grant_wr = (state_q == IDLE) && wr_req && !grant_rd;

`ifdef FRAME_MEM_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!wr_req || grant_wr) begin
        starve_d = '0;
      end else if (grant_rd && !starve_full) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  // Strict read priority: a pending write never forces its way in.
  assign starve_full = (STARVE_MAX < 0);
`endif

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_ack_d     = 1'b0;
    mem_oe_d     = 1'b0;
    mem_we_d     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d      = RD;
          mem_addr_d   = rd_addr;
          mem_oe_d     = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RD_LAT - 1);
        end else if (grant_wr) begin
          state_d      = WR;
          mem_addr_d   = wr_addr;
          mem_wdata_d  = wr_data;
          mem_we_d     = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(WR_CYC - 1);
        end
      end
      RD: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          rd_data_d  = mem_rdata;
          rd_valid_d = 1'b1;
          state_d    = DONE;
        end else begin
          mem_oe_d = 1'b1;
        end
      end
      WR: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          wr_ack_d = 1'b1;
          state_d  = DONE;
        end else begin
          mem_we_d = 1'b1;
        end
      end
      // Requests are ignored here so requesters can drop or re-aim req.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ack    = wr_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

- Single-port arbiter for the external frame memory (SRAM) holding the double-buffered image.
- Shares the memory between two requesters:
  - the HDMI transmitter's pixel fetch path (read side: 20-bit address, read request, data-ready);
  - the image writer that fills the back buffer (write side).
- Sequences every memory access with fixed read latency and write pulse width.
- Reads get priority so the display never underruns; a compile-time starvation guard bounds write stalls.

## Interface
Parameters:
- ADDR_W, 20, memory address width (bit 19 = frame select from the address bit flip)
- DATA_W, 24, pixel width (RGB 8:8:8)
- RD_LAT, 2, cycles mem_oe is held before mem_rdata is valid (≥1)
- WR_CYC, 2, cycles mem_we is held per write (≥1)
- STARVE_MAX, 8, consecutive read grants tolerated while a write waits (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- rd_req  in  1  read request from transmitter, held until rd_valid
- rd_addr  in  ADDR_W  read address, stable while rd_req high
- rd_data  out  DATA_W  read pixel, valid when rd_valid
- rd_valid  out  1  one-cycle pulse: rd_data valid, read complete
- wr_req  in  1  write request from image writer, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req high
- wr_data  in  DATA_W  write pixel, stable while wr_req high
- wr_ack  out  1  one-cycle pulse: write complete
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- mem_oe  out  1  output enable, high during read states
- mem_we  out  1  write enable, high during write states

## Operation
- State machine: IDLE, RD, WR, DONE.
- IDLE, grant decision:
  - rd_req only → RD.
  - wr_req only → WR.
  - Both high → RD, unless starve_cnt == STARVE_MAX, then WR.
  - Neither → stay IDLE.
- On grant, mem_addr (and mem_wdata for a write) are loaded from the granted requester.
- RD:
  - mem_oe=1 for exactly RD_LAT cycles; a wait counter runs 0..RD_LAT-1.
  - On the last cycle, rd_data <= mem_rdata and rd_valid <= 1; → DONE.
- WR:
  - mem_we=1 for exactly WR_CYC cycles.
  - On the last cycle, wr_ack <= 1 and mem_we <= 0; → DONE.
- DONE:
  - One cycle; rd_valid/wr_ack is high here.
  - Requests are ignored so the requester can drop or update req.
  - → IDLE.
- rd_data holds its last captured value until the next read completes.
- Starvation counter starve_cnt, width $clog2(STARVE_MAX+1):
  - +1 on each read grant while wr_req is high;
  - clears on a write grant or whenever wr_req is low in IDLE;
  - saturates at STARVE_MAX.
- No queuing: at most one access outstanding. A request raised mid-access waits for IDLE.

## Timing
- Reset: state IDLE; all outputs 0 (rd_data, rd_valid, wr_ack, mem_addr, mem_wdata, mem_oe, mem_we); starve_cnt 0; wait counter 0.
- Reset mid-access: the access aborts on the next edge, mem_we/mem_oe drop, and no rd_valid/wr_ack is issued.
- Read, rd_req seen in IDLE at cycle N:
  - mem_oe high at cycles N+1 .. N+RD_LAT;
  - rd_valid high at cycle N+RD_LAT+1.
  - Throughput: one read per RD_LAT+2 cycles.
- Write, wr_req seen in IDLE at cycle N:
  - mem_we high at cycles N+1 .. N+WR_CYC;
  - wr_ack at N+WR_CYC+1.
- mem_addr is constant throughout RD/WR; mem_oe and mem_we are never high together.
- A requester must deassert req, or present the next address, in the cycle after its ack/valid. Requests are re-sampled only in IDLE.

## Configuration
- FRAME_MEM_STARVE_GUARD_EN defined:
  - starve_cnt is implemented as described;
  - writes are guaranteed a grant after at most STARVE_MAX consecutive reads.
- Not defined:
  - strict read priority; starve_cnt logic is removed;
  - when both requests are high in IDLE, the read always wins.

## Structure
- Shared package frame_mem_pkg:
  - arb_state_t enum (IDLE, RD, WR, DONE);
  - ADDR_W/DATA_W default constants, shared with the transmitter and the image writer.
- One sub-module, arb_wait_counter:
  - loadable down-counter;
  - loaded with RD_LAT-1 or WR_CYC-1 on grant;
  - asserts a last-cycle flag at zero.

## Test plan
- Reset, then an idle run: all outputs stay 0; assert rst mid-write → mem_we low next cycle, no wr_ack.
- Single read at cycle 10, rd_addr=0x80001, mem_rdata=0xA5C3F0 → mem_oe cycles 11–12, rd_valid at 13, rd_data=0xA5C3F0.
- Single write at cycle 10, wr_addr=0x00010, wr_data=0x123456 → mem_we cycles 11–12 with that address/data, wr_ack at 13.
- rd_req and wr_req raised together in IDLE → read granted first, write granted in the next IDLE (cycle after read DONE).
- Continuous rd_req with wr_req held, macro defined → write granted after exactly 8 reads. Same stimulus, macro undefined → no write until rd_req drops.
- Back-to-back reads with new addresses each DONE cycle → one rd_valid every 4 cycles; mem_oe and mem_we are never high together.
